// File: rtl/ysyx_23060061_alu_arb_if.sv
// Bus bundle between two requesters, the shared ALU and the arbiter.
// The master side owns the requesters and the ALU; the slave side is the arbiter.
interface ysyx_23060061_alu_arb_if #(
    parameter int WIDTH = 32
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic [1:0]       req0_op;
    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic [1:0]       req1_op;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [1:0]       alu_op;
    logic [WIDTH-1:0] alu_out;
    logic             resp0_valid;
    logic             resp0_ready;
    logic             resp1_valid;
    logic             resp1_ready;
    logic [WIDTH-1:0] resp_data;

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        output req1_valid, req1_a, req1_b, req1_op,
        input  req0_ready, req1_ready,
        input  alu_a, alu_b, alu_op,
        output alu_out,
        input  resp0_valid, resp1_valid, resp_data,
        output resp0_ready, resp1_ready
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        input  req1_valid, req1_a, req1_b, req1_op,
        output req0_ready, req1_ready,
        output alu_a, alu_b, alu_op,
        input  alu_out,
        output resp0_valid, resp1_valid, resp_data,
        input  resp0_ready, resp1_ready
    );
endinterface

// File: rtl/ysyx_23060061_alu_arb.sv
// Two-requester arbiter in front of a shared combinational ALU (IDLE -> EXEC -> RESP).
// Define YSYX_23060061_ALU_ARB_RR_EN for round-robin grant; default is fixed priority (req0 wins).
//
// Handshake: a request transfers on a rising edge where reqN_valid && reqN_ready; a
// response transfers on a rising edge where respN_valid && respN_ready. Valid never
// depends combinationally on the matching ready.
module ysyx_23060061_alu_arb #(
    parameter int WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    ysyx_23060061_alu_arb_if.slave    bus_io,
    output logic [1:0]                state_o
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]       state_q, state_d;
    logic             grant_q;
    logic [WIDTH-1:0] alu_a_q, alu_b_q, resp_data_q;
    logic [1:0]       alu_op_q;
    logic             any_valid;
    logic             sel;
    logic             accept;
    logic             resp_fire;

    assign any_valid = bus_io.req0_valid | bus_io.req1_valid;
    assign accept    = (state_q == S_IDLE) && any_valid;
    assign resp_fire = (state_q == S_RESP) &&
                       (grant_q ? bus_io.resp1_ready : bus_io.resp0_ready);

`ifdef YSYX_23060061_ALU_ARB_RR_EN
    // prio_q names the requester that wins a tie; it flips away from each winner.
    logic prio_q;

    always_comb begin
        if (bus_io.req0_valid && bus_io.req1_valid) begin
            sel = prio_q;
        end else begin
            sel = bus_io.req1_valid;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_q <= 1'b0;
        end else if (accept) begin
            prio_q <= ~sel;
        end
    end
`else
    assign sel = ~bus_io.req0_valid;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (any_valid) state_d = S_EXEC;
            S_EXEC:  state_d = S_RESP;
            S_RESP:  if (resp_fire) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_q     <= 1'b0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= 2'b00;
            resp_data_q <= '0;
        end else begin
            if (accept) begin
                grant_q  <= sel;
                alu_a_q  <= sel ? bus_io.req1_a  : bus_io.req0_a;
                alu_b_q  <= sel ? bus_io.req1_b  : bus_io.req0_b;
                alu_op_q <= sel ? bus_io.req1_op : bus_io.req0_op;
            end
            if (state_q == S_EXEC) begin
                resp_data_q <= bus_io.alu_out;
            end
        end
    end

    assign bus_io.req0_ready  = (state_q == S_IDLE) && !sel && bus_io.req0_valid;
    assign bus_io.req1_ready  = (state_q == S_IDLE) &&  sel && bus_io.req1_valid;
    assign bus_io.resp0_valid = (state_q == S_RESP) && !grant_q;
    assign bus_io.resp1_valid = (state_q == S_RESP) &&  grant_q;
    assign bus_io.alu_a       = alu_a_q;
    assign bus_io.alu_b       = alu_b_q;
    assign bus_io.alu_op      = alu_op_q;
    assign bus_io.resp_data   = resp_data_q;
    assign state_o            = state_q;
endmodule

// File: tb/tb_ysyx_23060061_alu_arb.sv
// Directed bench for ysyx_23060061_alu_arb; the shared ALU is modelled here.
module tb_ysyx_23060061_alu_arb;
    localparam int WIDTH = 32;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;
`ifdef YSYX_23060061_ALU_ARB_RR_EN
    localparam bit RR_MODE = 1'b1;
`else
    localparam bit RR_MODE = 1'b0;
`endif

    typedef struct {
        bit               n;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [1:0]       op;
        logic [WIDTH-1:0] exp;
    } vec_t;

    logic       clk;
    logic       rst;
    logic [1:0] state;
    int         n_vec;
    int         n_err;

    ysyx_23060061_alu_arb_if #(.WIDTH(WIDTH)) bus ();

    ysyx_23060061_alu_arb #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus_io  (bus.slave),
        .state_o (state)
    );

    // Shared ALU: 00 add, 01 pass b, 10 add with bit 0 cleared, 11 a-b.
    always_comb begin
        case (bus.alu_op)
            2'b00:   bus.alu_out = bus.alu_a + bus.alu_b;
            2'b01:   bus.alu_out = bus.alu_b;
            2'b10:   bus.alu_out = (bus.alu_a + bus.alu_b) & ~32'd1;
            default: bus.alu_out = bus.alu_a - bus.alu_b;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic drive_req(input bit n, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                             input logic [1:0] op);
        if (n) begin
            bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_b = b; bus.req1_op = op;
        end else begin
            bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b; bus.req0_op = op;
        end
    endtask

    task automatic drop_req(input bit n);
        if (n) bus.req1_valid = 1'b0;
        else   bus.req0_valid = 1'b0;
    endtask

    task automatic drive_resp_ready(input bit n, input logic v);
        if (n) bus.resp1_ready = v;
        else   bus.resp0_ready = v;
    endtask

    task automatic test_reset;
        bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_op = 2'b00;
        bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_op = 2'b00;
        bus.resp0_ready = 1'b0; bus.resp1_ready = 1'b0;
        rst = 1'b0;
        #1 rst = 1'b1;
        #2;
        n_vec++; if (state !== ST_IDLE) begin n_err++; $display("FAIL reset_state: got %0d expected %0d", state, ST_IDLE); end
        n_vec++; if ({bus.req1_ready, bus.req0_ready} !== 2'b00) begin n_err++; $display("FAIL reset_ready: got %b expected 00", {bus.req1_ready, bus.req0_ready}); end
        n_vec++; if ({bus.resp1_valid, bus.resp0_valid} !== 2'b00) begin n_err++; $display("FAIL reset_resp_valid: got %b expected 00", {bus.resp1_valid, bus.resp0_valid}); end
        n_vec++; if ({bus.alu_a, bus.alu_b, bus.alu_op} !== '0) begin n_err++; $display("FAIL reset_alu_regs: got %h %h %b expected zero", bus.alu_a, bus.alu_b, bus.alu_op); end
        n_vec++; if (bus.resp_data !== '0) begin n_err++; $display("FAIL reset_resp_data: got %h expected 0", bus.resp_data); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_ops;
        vec_t v[6];
        logic [1:0] exp_sel;
        v[0] = '{1'b0, 32'd5,          32'd3,          2'b00, 32'd8};
        v[1] = '{1'b1, 32'h0000_1003,  32'h0,          2'b10, 32'h0000_1002};
        v[2] = '{1'b1, 32'd0,          32'd1,          2'b11, 32'hFFFF_FFFF};
        v[3] = '{1'b0, 32'hFFFF_FFFF,  32'd2,          2'b00, 32'd1};
        v[4] = '{1'b0, 32'h0000_1234,  32'h0000_ABCD,  2'b01, 32'h0000_ABCD};
        v[5] = '{1'b1, 32'd7,          32'd7,          2'b10, 32'd14};
        for (int i = 0; i < 6; i++) begin
            exp_sel = v[i].n ? 2'b10 : 2'b01;
            @(negedge clk);
            drive_req(v[i].n, v[i].a, v[i].b, v[i].op);
            #1;
            n_vec++; if ({bus.req1_ready, bus.req0_ready} !== exp_sel) begin n_err++; $display("FAIL ops%0d_ready: got %b expected %b", i, {bus.req1_ready, bus.req0_ready}, exp_sel); end
            @(negedge clk);
            drop_req(v[i].n);
            #1;
            n_vec++; if (state !== ST_EXEC) begin n_err++; $display("FAIL ops%0d_exec_state: got %0d expected %0d", i, state, ST_EXEC); end
            n_vec++; if ({bus.alu_a, bus.alu_b, bus.alu_op} !== {v[i].a, v[i].b, v[i].op}) begin n_err++; $display("FAIL ops%0d_alu_regs: got %h %h %b expected %h %h %b", i, bus.alu_a, bus.alu_b, bus.alu_op, v[i].a, v[i].b, v[i].op); end
            n_vec++; if ({bus.resp1_valid, bus.resp0_valid} !== 2'b00) begin n_err++; $display("FAIL ops%0d_early_resp: got %b expected 00", i, {bus.resp1_valid, bus.resp0_valid}); end
            @(negedge clk);
            #1;
            n_vec++; if ({bus.resp1_valid, bus.resp0_valid} !== exp_sel) begin n_err++; $display("FAIL ops%0d_resp_valid: got %b expected %b", i, {bus.resp1_valid, bus.resp0_valid}, exp_sel); end
            n_vec++; if (bus.resp_data !== v[i].exp) begin n_err++; $display("FAIL ops%0d_resp_data: got %h expected %h", i, bus.resp_data, v[i].exp); end
            drive_resp_ready(v[i].n, 1'b1);
            @(negedge clk);
            drive_resp_ready(v[i].n, 1'b0);
            #1;
            n_vec++; if (state !== ST_IDLE || {bus.resp1_valid, bus.resp0_valid} !== 2'b00) begin n_err++; $display("FAIL ops%0d_done: got state %0d valid %b expected 0 00", i, state, {bus.resp1_valid, bus.resp0_valid}); end
        end
    endtask

    task automatic test_both_valid;
        logic [1:0]       exp_sel2;
        logic [WIDTH-1:0] exp_data2;
        bit               g2;
        g2        = RR_MODE;
        exp_sel2  = RR_MODE ? 2'b10 : 2'b01;
        exp_data2 = RR_MODE ? 32'd7 : 32'd6;
        @(negedge clk);
        drive_req(1'b0, 32'd10, 32'd4, 2'b11);
        drive_req(1'b1, 32'd0,  32'd7, 2'b01);
        #1;
        n_vec++; if ({bus.req1_ready, bus.req0_ready} !== 2'b01) begin n_err++; $display("FAIL both_first_grant: got %b expected 01", {bus.req1_ready, bus.req0_ready}); end
        @(negedge clk);
        #1;
        n_vec++; if ({bus.req1_ready, bus.req0_ready} !== 2'b00) begin n_err++; $display("FAIL both_exec_ready: got %b expected 00", {bus.req1_ready, bus.req0_ready}); end
        @(negedge clk);
        #1;
        n_vec++; if ({bus.resp1_valid, bus.resp0_valid} !== 2'b01 || bus.resp_data !== 32'd6) begin n_err++; $display("FAIL both_first_resp: got %b %h expected 01 00000006", {bus.resp1_valid, bus.resp0_valid}, bus.resp_data); end
        bus.resp0_ready = 1'b1;
        @(negedge clk);
        bus.resp0_ready = 1'b0;
        #1;
        n_vec++; if ({bus.req1_ready, bus.req0_ready} !== exp_sel2) begin n_err++; $display("FAIL both_second_grant: got %b expected %b", {bus.req1_ready, bus.req0_ready}, exp_sel2); end
        @(negedge clk);
        drop_req(1'b0);
        drop_req(1'b1);
        @(negedge clk);
        #1;
        n_vec++; if ({bus.resp1_valid, bus.resp0_valid} !== exp_sel2) begin n_err++; $display("FAIL both_second_valid: got %b expected %b", {bus.resp1_valid, bus.resp0_valid}, exp_sel2); end
        n_vec++; if (bus.resp_data !== exp_data2) begin n_err++; $display("FAIL both_second_data: got %h expected %h", bus.resp_data, exp_data2); end
        drive_resp_ready(g2, 1'b1);
        @(negedge clk);
        drive_resp_ready(g2, 1'b0);
        #1;
        n_vec++; if (state !== ST_IDLE) begin n_err++; $display("FAIL both_done_state: got %0d expected %0d", state, ST_IDLE); end
    endtask

    task automatic test_backpressure;
        @(negedge clk);
        drive_req(1'b0, 32'd1, 32'd2, 2'b00);
        #1;
        n_vec++; if (bus.req0_ready !== 1'b1) begin n_err++; $display("FAIL bp_accept0: got %b expected 1", bus.req0_ready); end
        @(negedge clk);
        drop_req(1'b0);
        drive_req(1'b1, 32'd9, 32'd1, 2'b11);
        #1;
        n_vec++; if (bus.req1_ready !== 1'b0) begin n_err++; $display("FAIL bp_exec_ready1: got %b expected 0", bus.req1_ready); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            n_vec++; if (bus.resp0_valid !== 1'b1 || bus.resp_data !== 32'd3) begin n_err++; $display("FAIL bp_hold%0d_resp: got %b %h expected 1 00000003", i, bus.resp0_valid, bus.resp_data); end
            n_vec++; if (bus.req1_ready !== 1'b0) begin n_err++; $display("FAIL bp_hold%0d_ready1: got %b expected 0", i, bus.req1_ready); end
        end
        @(negedge clk);
        bus.resp0_ready = 1'b1;
        #1;
        n_vec++; if (bus.req1_ready !== 1'b0 || bus.resp_data !== 32'd3) begin n_err++; $display("FAIL bp_handshake: got ready1 %b data %h expected 0 00000003", bus.req1_ready, bus.resp_data); end
        @(negedge clk);
        bus.resp0_ready = 1'b0;
        #1;
        n_vec++; if (bus.req1_ready !== 1'b1) begin n_err++; $display("FAIL bp_accept1: got %b expected 1", bus.req1_ready); end
        @(negedge clk);
        drop_req(1'b1);
        @(negedge clk);
        #1;
        n_vec++; if (bus.resp1_valid !== 1'b1 || bus.resp_data !== 32'd8) begin n_err++; $display("FAIL bp_resp1: got %b %h expected 1 00000008", bus.resp1_valid, bus.resp_data); end
        bus.resp1_ready = 1'b1;
        @(negedge clk);
        bus.resp1_ready = 1'b0;
    endtask

    task automatic test_reset_in_exec;
        @(negedge clk);
        drive_req(1'b0, 32'd20, 32'd22, 2'b00);
        @(negedge clk);
        drop_req(1'b0);
        #2 rst = 1'b1;
        #1;
        n_vec++; if (state !== ST_IDLE) begin n_err++; $display("FAIL rexec_state: got %0d expected %0d", state, ST_IDLE); end
        n_vec++; if ({bus.alu_a, bus.alu_b, bus.alu_op, bus.resp_data} !== '0) begin n_err++; $display("FAIL rexec_regs: got %h %h %b %h expected zero", bus.alu_a, bus.alu_b, bus.alu_op, bus.resp_data); end
        n_vec++; if ({bus.req1_ready, bus.req0_ready, bus.resp1_valid, bus.resp0_valid} !== 4'b0000) begin n_err++; $display("FAIL rexec_flags: got %b expected 0000", {bus.req1_ready, bus.req0_ready, bus.resp1_valid, bus.resp0_valid}); end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            n_vec++; if ({bus.resp1_valid, bus.resp0_valid} !== 2'b00) begin n_err++; $display("FAIL rexec_no_resp%0d: got %b expected 00", i, {bus.resp1_valid, bus.resp0_valid}); end
        end
        @(negedge clk);
        drive_req(1'b1, 32'd3, 32'd4, 2'b00);
        #1;
        n_vec++; if (bus.req1_ready !== 1'b1) begin n_err++; $display("FAIL rexec_accept: got %b expected 1", bus.req1_ready); end
        @(negedge clk);
        drop_req(1'b1);
        #1;
        n_vec++; if (bus.resp1_valid !== 1'b0) begin n_err++; $display("FAIL rexec_latency1: got %b expected 0", bus.resp1_valid); end
        @(negedge clk);
        #1;
        n_vec++; if (bus.resp1_valid !== 1'b1 || bus.resp_data !== 32'd7) begin n_err++; $display("FAIL rexec_resp: got %b %h expected 1 00000007", bus.resp1_valid, bus.resp_data); end
        bus.resp1_ready = 1'b1;
        @(negedge clk);
        bus.resp1_ready = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_ops();
        test_both_valid();
        test_backpressure();
        test_reset_in_exec();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
